// File: rtl/spi_pkg.sv
// Shared widths and FSM state type for the SPI slave receiver.
// Optional input synchronizers are enabled with SPI_RX_SYNC_EN.
package spi_pkg;
  localparam int SPI_WORD_W = 12;
  localparam int SPI_CNT_W  = 4;

  localparam logic [SPI_CNT_W-1:0] SPI_LAST =
    SPI_CNT_W'(SPI_WORD_W - 1);

  typedef logic [SPI_WORD_W-1:0] spi_word_t;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    WAIT_CS
  } spi_state_t;
endpackage

// File: rtl/spi_slave_rx_if.sv
// SPI pins plus the word-output valid/ready handshake and status flags.
// master drives the serial pins and dout_ready; slave is the receiver.
interface spi_slave_rx_if;
  import spi_pkg::*;

  logic      sclk;
  logic      cs;
  logic      mosi;
  spi_word_t dout;
  logic      dout_valid;
  logic      dout_ready;
  logic      frame_err;
  logic      overrun;

  modport slave (
    input  sclk, cs, mosi, dout_ready,
    output dout, dout_valid, frame_err, overrun
  );

  modport master (
    output sclk, cs, mosi, dout_ready,
    input  dout, dout_valid, frame_err, overrun
  );
endinterface

// File: rtl/spi_sync_edge.sv
// Input register stage with sclk falling-edge and cs edge detection.
// SPI_RX_SYNC_EN inserts 2-flop synchronizers ahead of the stage.
module spi_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_sclk,
  input  logic i_cs,
  input  logic i_mosi,
  output logic o_sclk_fall,
  output logic o_cs_rise,
  output logic o_cs_fall,
  output logic o_mosi
);
  logic w_sclk;
  logic w_cs;
  logic w_mosi;

`ifdef SPI_RX_SYNC_EN
  localparam int VLD_W = 4;

  logic [1:0] r_sclk_s;
  logic [1:0] r_cs_s;
  logic [1:0] r_mosi_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sclk_s <= 2'b00;
      r_cs_s   <= 2'b11;
      r_mosi_s <= 2'b00;
    end else begin
      r_sclk_s <= {r_sclk_s[0], i_sclk};
      r_cs_s   <= {r_cs_s[0], i_cs};
      r_mosi_s <= {r_mosi_s[0], i_mosi};
    end
  end

  assign w_sclk = r_sclk_s[1];
  assign w_cs   = r_cs_s[1];
  assign w_mosi = r_mosi_s[1];
`else
  localparam int VLD_W = 2;

  assign w_sclk = i_sclk;
  assign w_cs   = i_cs;
  assign w_mosi = i_mosi;
`endif

  logic             r_sclk;
  logic             r_sclk_d;
  logic             r_cs;
  logic             r_cs_d;
  logic             r_mosi;
  logic [VLD_W-1:0] r_vld;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sclk   <= 1'b0;
      r_sclk_d <= 1'b0;
      r_cs     <= 1'b1;
      r_cs_d   <= 1'b1;
      r_mosi   <= 1'b0;
      r_vld    <= '0;
    end else begin
      r_sclk   <= w_sclk;
      r_sclk_d <= r_sclk;
      r_cs     <= w_cs;
      r_cs_d   <= r_cs;
      r_mosi   <= w_mosi;
      r_vld    <= {r_vld[VLD_W-2:0], 1'b1};
    end
  end

  // cs edges are masked until the pipeline holds real samples,
  // so a cs already low at reset release is not seen as a fall
  assign o_sclk_fall = r_sclk_d & ~r_sclk;
  assign o_cs_fall   = r_vld[VLD_W-1] & r_cs_d & ~r_cs;
  assign o_cs_rise   = r_vld[VLD_W-1] & ~r_cs_d & r_cs;
  assign o_mosi      = r_mosi;
endmodule

// File: rtl/spi_slave_rx.sv
// 12-bit LSB-first SPI slave receiver with valid/ready word output.
// Define SPI_RX_SYNC_EN for 2-flop input synchronizers.
module spi_slave_rx
  import spi_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  spi_slave_rx_if.slave  bus
);
  logic w_sclk_fall;
  logic w_cs_rise;
  logic w_cs_fall;
  logic w_mosi;

  spi_sync_edge u_sync (
    .clk         (clk),
    .rst         (rst),
    .i_sclk      (bus.sclk),
    .i_cs        (bus.cs),
    .i_mosi      (bus.mosi),
    .o_sclk_fall (w_sclk_fall),
    .o_cs_rise   (w_cs_rise),
    .o_cs_fall   (w_cs_fall),
    .o_mosi      (w_mosi)
  );

  spi_state_t           r_state;
  logic [SPI_CNT_W-1:0] r_cnt;
  spi_word_t            r_shift;
  spi_word_t            r_dout;
  logic                 r_dout_valid;
  logic                 r_frame_err;
  logic                 r_overrun;

  spi_word_t w_word;
  logic      w_take;
  logic      w_room;

  assign w_word = {w_mosi, r_shift[SPI_WORD_W-1:1]};
  assign w_take = r_dout_valid & bus.dout_ready;
  assign w_room = ~r_dout_valid | bus.dout_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_shift      <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      if (w_take)
        r_dout_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_cs_fall) begin
            r_state <= RECV;
            r_shift <= w_sclk_fall ? w_word : '0;
            r_cnt   <= w_sclk_fall ? SPI_CNT_W'(1) : '0;
          end
        end
        RECV: begin
          if (w_cs_rise) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_frame_err <= (r_cnt != '0);
          end else if (w_sclk_fall) begin
            if (r_cnt == SPI_LAST) begin
              r_state <= WAIT_CS;
              r_cnt   <= '0;
              r_shift <= '0;
              if (w_room) begin
                r_dout       <= w_word;
                r_dout_valid <= 1'b1;
              end else begin
                r_overrun <= 1'b1;
              end
            end else begin
              r_shift <= w_word;
              r_cnt   <= r_cnt + 1'b1;
            end
          end
        end
        WAIT_CS: begin
          if (w_cs_rise)
            r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_dout_valid;
  assign bus.frame_err  = r_frame_err;
  assign bus.overrun    = r_overrun;
endmodule

// File: tb/tb_spi_slave_rx.sv
// Scoreboard bench for spi_slave_rx: SPI master model plus
// an output monitor feeding a received-word queue.
module tb_spi_slave_rx;
  import spi_pkg::*;

  localparam int HALF = 4;
`ifdef SPI_RX_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic clk;
  logic rst;

  spi_slave_rx_if bus ();

  spi_slave_rx u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int        n_tests;
  int        n_fail;
  int        vcnt;
  int        fe_cnt;
  spi_word_t exp_q[$];
  spi_word_t rx_q[$];

  always @(negedge clk) begin
    if (bus.dout_valid)
      vcnt++;
    if (bus.frame_err)
      fe_cnt++;
    if (bus.dout_valid && bus.dout_ready)
      rx_q.push_back(bus.dout);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic spi_bits(input spi_word_t w, input int n);
    spi_word_t v;
    v = w;
    for (int i = 0; i < n; i++) begin
      bus.mosi = v[0];
      v = {1'b1, v[SPI_WORD_W-1:1]};
      bus.sclk = 1'b1;
      tick(HALF);
      bus.sclk = 1'b0;
      tick(HALF);
    end
  endtask

  task automatic spi_frame(input spi_word_t w, input int n);
    bus.cs = 1'b0;
    tick(3);
    spi_bits(w, n);
    tick(2);
    bus.cs = 1'b1;
    tick(6);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    tick(3);
    n_tests++;
    if (bus.dout !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_dout got %h want 000", bus.dout);
    end
    n_tests++;
    if (bus.dout_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid got %b want 0", bus.dout_valid);
    end
    n_tests++;
    if (bus.frame_err !== 1'b0 || bus.overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags got fe=%b ov=%b want 0 0",
               bus.frame_err, bus.overrun);
    end
    rst = 1'b1;
    tick(4);
  endtask

  task automatic test_basic;
    int v0;
    int f0;
    spi_word_t got;
    spi_word_t want;
    bus.dout_ready = 1'b1;
    v0 = vcnt;
    f0 = fe_cnt;
    exp_q.push_back(12'hA5C);
    spi_frame(12'hA5C, 12);
    n_tests++;
    if (rx_q.size() != 1 || exp_q.size() != 1) begin
      n_fail++;
      $display("FAIL basic_count got %0d want 1", rx_q.size());
      rx_q.delete();
      exp_q.delete();
    end else begin
      got = rx_q.pop_front();
      want = exp_q.pop_front();
      if (got !== want) begin
        n_fail++;
        $display("FAIL basic_word got %h want %h", got, want);
      end
    end
    n_tests++;
    if (vcnt - v0 != 1) begin
      n_fail++;
      $display("FAIL basic_valid_len got %0d want 1", vcnt - v0);
    end
    n_tests++;
    if (fe_cnt != f0) begin
      n_fail++;
      $display("FAIL basic_frame_err got %0d want 0", fe_cnt - f0);
    end
  endtask

  task automatic test_short_frame;
    int v0;
    int f0;
    spi_word_t got;
    spi_word_t want;
    bus.dout_ready = 1'b1;
    v0 = vcnt;
    f0 = fe_cnt;
    spi_frame(12'h01F, 5);
    n_tests++;
    if (fe_cnt - f0 != 1) begin
      n_fail++;
      $display("FAIL short_fe got %0d want 1", fe_cnt - f0);
    end
    n_tests++;
    if (vcnt != v0 || bus.dout_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL short_valid got %0d want 0", vcnt - v0);
    end
    exp_q.push_back(12'h3F0);
    spi_frame(12'h3F0, 12);
    n_tests++;
    if (rx_q.size() != 1 || exp_q.size() != 1) begin
      n_fail++;
      $display("FAIL short_next_count got %0d want 1", rx_q.size());
      rx_q.delete();
      exp_q.delete();
    end else begin
      got = rx_q.pop_front();
      want = exp_q.pop_front();
      if (got !== want) begin
        n_fail++;
        $display("FAIL short_next_word got %h want %h", got, want);
      end
    end
  endtask

  task automatic test_overrun;
    spi_word_t got;
    spi_word_t want;
    bus.dout_ready = 1'b0;
    exp_q.push_back(12'h001);
    spi_frame(12'h001, 12);
    spi_frame(12'hFFF, 12);
    n_tests++;
    if (bus.dout !== 12'h001 || bus.dout_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_hold got %h/%b want 001/1",
               bus.dout, bus.dout_valid);
    end
    n_tests++;
    if (bus.overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_flag got %b want 1", bus.overrun);
    end
    bus.dout_ready = 1'b1;
    tick(1);
    bus.dout_ready = 1'b0;
    tick(2);
    n_tests++;
    if (rx_q.size() != 1 || exp_q.size() != 1) begin
      n_fail++;
      $display("FAIL ovr_count got %0d want 1", rx_q.size());
      rx_q.delete();
      exp_q.delete();
    end else begin
      got = rx_q.pop_front();
      want = exp_q.pop_front();
      if (got !== want) begin
        n_fail++;
        $display("FAIL ovr_word got %h want %h", got, want);
      end
    end
    n_tests++;
    if (bus.overrun !== 1'b1 || bus.dout_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_sticky got ov=%b v=%b want 1 0",
               bus.overrun, bus.dout_valid);
    end
  endtask

  task automatic test_ready_same_cycle;
    spi_word_t got;
    spi_word_t want;
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(4);
    bus.dout_ready = 1'b0;
    exp_q.push_back(12'h7FF);
    spi_frame(12'h7FF, 12);
    exp_q.push_back(12'h800);
    bus.cs = 1'b0;
    tick(3);
    spi_bits(12'h800, 11);
    bus.mosi = 1'b1;
    bus.sclk = 1'b1;
    tick(HALF);
    bus.sclk = 1'b0;
    tick(LAT);
    bus.dout_ready = 1'b1;
    tick(1);
    bus.dout_ready = 1'b0;
    tick(3);
    n_tests++;
    if (bus.dout !== 12'h800 || bus.dout_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL same_load got %h/%b want 800/1",
               bus.dout, bus.dout_valid);
    end
    n_tests++;
    if (bus.overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL same_overrun got %b want 0", bus.overrun);
    end
    bus.cs = 1'b1;
    tick(4);
    bus.dout_ready = 1'b1;
    tick(1);
    bus.dout_ready = 1'b0;
    tick(2);
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (rx_q.size() == 0 || exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL same_word%0d got none want one", k);
      end else begin
        got = rx_q.pop_front();
        want = exp_q.pop_front();
        if (got !== want) begin
          n_fail++;
          $display("FAIL same_word%0d got %h want %h", k, got, want);
        end
      end
    end
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic test_extra_edges;
    int v0;
    spi_word_t got;
    spi_word_t want;
    bus.dout_ready = 1'b1;
    v0 = vcnt;
    exp_q.push_back(12'h555);
    spi_frame(12'h555, 14);
    n_tests++;
    if (vcnt - v0 != 1) begin
      n_fail++;
      $display("FAIL extra_words got %0d want 1", vcnt - v0);
    end
    n_tests++;
    if (rx_q.size() != 1 || exp_q.size() != 1) begin
      n_fail++;
      $display("FAIL extra_count got %0d want 1", rx_q.size());
      rx_q.delete();
      exp_q.delete();
    end else begin
      got = rx_q.pop_front();
      want = exp_q.pop_front();
      if (got !== want) begin
        n_fail++;
        $display("FAIL extra_word got %h want %h", got, want);
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    int v0;
    int f0;
    spi_word_t got;
    spi_word_t want;
    bus.dout_ready = 1'b1;
    bus.cs = 1'b0;
    tick(3);
    spi_bits(12'h03F, 6);
    rst = 1'b0;
    #1;
    n_tests++;
    if (bus.dout !== 12'h000 || bus.dout_valid !== 1'b0 ||
        bus.frame_err !== 1'b0 || bus.overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rst got %h/%b/%b/%b want 000/0/0/0",
               bus.dout, bus.dout_valid, bus.frame_err, bus.overrun);
    end
    tick(2);
    rst = 1'b1;
    tick(2);
    v0 = vcnt;
    f0 = fe_cnt;
    spi_bits(12'hFFF, 12);
    bus.cs = 1'b1;
    tick(6);
    n_tests++;
    if (vcnt != v0 || fe_cnt != f0) begin
      n_fail++;
      $display("FAIL mid_ignore got v=%0d fe=%0d want 0 0",
               vcnt - v0, fe_cnt - f0);
    end
    exp_q.push_back(12'h123);
    spi_frame(12'h123, 12);
    n_tests++;
    if (rx_q.size() != 1 || exp_q.size() != 1) begin
      n_fail++;
      $display("FAIL mid_next_count got %0d want 1", rx_q.size());
    end else begin
      got = rx_q.pop_front();
      want = exp_q.pop_front();
      if (got !== want) begin
        n_fail++;
        $display("FAIL mid_next_word got %h want %h", got, want);
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    vcnt = 0;
    fe_cnt = 0;
    rst = 1'b0;
    bus.sclk = 1'b0;
    bus.cs = 1'b1;
    bus.mosi = 1'b0;
    bus.dout_ready = 1'b0;
    test_reset();
    test_basic();
    test_short_frame();
    test_overrun();
    test_ready_same_cycle();
    test_extra_edges();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end
endmodule
